// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - read/accumulate/write sequencer for an NxN matrix multiply C = A x B
//
// Ports:
//   clk            single rising-edge clock
//   rst            synchronous active-high reset; aborts any run in progress
//   start          request one full run (sampled only while idle)
//   busy           high from the first issue cycle through the done cycle
//   done           one-cycle pulse at run completion
//   rd_en          read enable for MEM_A and MEM_B (data returns one cycle later)
//   addr_a         MEM_A read address {i,k}
//   addr_b         MEM_B read address {k,j}
//   a_data/b_data  MEM_A / MEM_B read data
//   we_c           MEM_C write enable, one cycle per C element
//   addr_c         MEM_C write address {i,j}
//   c_data         MEM_C write data, straight from the accumulator register
module mm_sequencer #(
  parameter int DIM_LOG2 = 6,
  parameter int DW       = 8,
  parameter int CW       = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [2*DIM_LOG2-1:0] addr_a,
  output logic [2*DIM_LOG2-1:0] addr_b,
  input  logic [DW-1:0]         a_data,
  input  logic [DW-1:0]         b_data,
  output logic                  we_c,
  output logic [2*DIM_LOG2-1:0] addr_c,
  output logic [CW-1:0]         c_data
);

  localparam int AW = 2 * DIM_LOG2;
  localparam int IW = 3 * DIM_LOG2;
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;      // {i,j,k} of the element being issued this cycle
  logic            r_drain;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_en;

  // Stage 1: tags travelling alongside the read data that arrives this cycle
  logic            r_p1_valid;
  logic            r_p1_first;
  logic            r_p1_last;
  logic [AW-1:0]   r_p1_ij;

  logic [CW-1:0]   r_acc;
  logic            r_we_c;
  logic [AW-1:0]   r_addr_c;

  logic [DIM_LOG2-1:0] w_i;
  logic [DIM_LOG2-1:0] w_j;
  logic [DIM_LOG2-1:0] w_k;
  logic [2*DW-1:0]     w_prod_raw;
  logic [CW-1:0]       w_prod;

  assign w_i = r_idx[IW-1 -: DIM_LOG2];
  assign w_j = r_idx[AW-1 -: DIM_LOG2];
  assign w_k = r_idx[DIM_LOG2-1:0];

  assign w_prod_raw = {{DW{1'b0}}, a_data} * {{DW{1'b0}}, b_data};
  assign w_prod     = {{(CW-2*DW){1'b0}}, w_prod_raw};

  assign busy   = r_busy;
  assign done   = r_done;
  assign rd_en  = r_rd_en;
  assign addr_a = {w_i, w_k};
  assign addr_b = {w_k, w_j};
  assign we_c   = r_we_c;
  assign addr_c = r_addr_c;
  assign c_data = r_acc;

  // Control FSM. The single {i,j,k} counter wraps back to zero on the last
  // issue, so every run (and every idle period) starts from (0,0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_drain <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end
        end
        S_RUN: begin
          r_idx <= r_idx + IDX_ONE;
          if (&r_idx) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Two cycles: one for the last read to return, one for the final write
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accumulate pipeline: the write of element (i,j) and the k=0 load of the
  // next element land in the same cycle, so no bubble is needed between them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_valid <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_ij    <= '0;
      r_acc      <= '0;
      r_we_c     <= 1'b0;
      r_addr_c   <= '0;
    end else begin
      r_p1_valid <= r_rd_en;
      r_p1_first <= (w_k == '0);
      r_p1_last  <= &w_k;
      r_p1_ij    <= {w_i, w_j};
      if (r_p1_valid) begin
        r_acc <= r_p1_first ? w_prod : r_acc + w_prod;
      end
      r_we_c <= r_p1_valid & r_p1_last;
      if (r_p1_valid & r_p1_last) begin
        r_addr_c <= r_p1_ij;
      end
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - self-checking bench for mm_sequencer (N=16 instance)
module tb_mm_sequencer;

  localparam int DL = 4;
  localparam int N  = 1 << DL;
  localparam int NN = N * N;
  localparam int NC = NN * N;
  localparam int AW = 2 * DL;
  localparam int DW = 8;
  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en, we_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] c_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // pattern: 0 identity, 1 random, 2 all 0xFF; restart_at/reset_at 0 = none
  typedef struct {
    int pa;
    int pb;
    int restart_at;
    int reset_at;
    int exp_dones;
    int exp_writes;
    int exp_c0;
  } vec_t;
  vec_t tbl[5];

  mm_sequencer #(.DIM_LOG2(DL), .DW(DW), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .a_data (a_data),
    .b_data (b_data),
    .we_c   (we_c),
    .addr_c (addr_c),
    .c_data (c_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories for A and B
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[addr_a];
      b_data <= mem_b[addr_b];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat, input bit is_a);
    logic [DW-1:0] val;
    for (int idx = 0; idx < NN; idx++) begin
      case (pat)
        0:       val = ((idx / N) == (idx % N)) ? 8'd1 : 8'd0;
        2:       val = 8'hFF;
        default: val = 8'($urandom_range(0, 255));
      endcase
      if (is_a) mem_a[idx] = val;
      else      mem_b[idx] = val;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   sum;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum = sum + mem_a[i*N+k] * mem_b[k*N+j];
        e.addr = AW'(i * N + j);
        e.data = CW'(sum);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   writes = 0, dones = 0, first_w = 0, last_w = 0, done_cyc = 0;
    int   busy_err = 0, rd_err = 0;
    int   busy_end, rd_end, limit;
    exp_t e;
    busy_end = (v.reset_at > 0) ? v.reset_at : NC + 3;
    rd_end   = (v.reset_at > 0) ? v.reset_at : NC;
    limit    = (v.reset_at > 0) ? v.reset_at + 30 : NC + 8;
    fill(v.pa, 1'b1);
    fill(v.pb, 1'b0);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (busy !== (cyc <= busy_end)) busy_err++;
      if (rd_en !== (cyc <= rd_end)) rd_err++;
      if (cyc == 1) begin
        check("first_rd_en", rd_en, 1);
        check("first_addr_a", addr_a, 0);
        check("first_addr_b", addr_b, 0);
      end
      if (cyc == 2) begin
        check("second_addr_a", addr_a, 1);
        check("second_addr_b", addr_b, N);
      end
      if (cyc == NC && v.reset_at == 0) begin
        check("last_addr_a", addr_a, NN - 1);
        check("last_addr_b", addr_b, NN - 1);
      end
      if (we_c === 1'b1) begin
        writes++;
        if (first_w == 0) first_w = cyc;
        last_w = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra_write: got addr %0d expected no write", addr_c);
        end else begin
          e = sb.pop_front();
          check("c_addr", addr_c, e.addr);
          check("c_data", c_data, e.data);
        end
        if (writes == 1 && v.exp_c0 >= 0) check("c_const", c_data, v.exp_c0);
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = cyc;
      end
      if (v.reset_at > 0 && cyc == v.reset_at + 1) begin
        check("abort_ctrl", {busy, done, rd_en, we_c}, 0);
        check("abort_addr_a", addr_a, 0);
        check("abort_addr_b", addr_b, 0);
        check("abort_addr_c", addr_c, 0);
        check("abort_c_data", c_data, 0);
      end
      start = (cyc == v.restart_at);
      rst   = (v.reset_at > 0 && cyc == v.reset_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    check("writes", writes, v.exp_writes);
    check("dones", dones, v.exp_dones);
    check("busy_profile_errs", busy_err, 0);
    check("rd_en_profile_errs", rd_err, 0);
    if (v.reset_at == 0) begin
      check("first_write_cycle", first_w, N + 2);
      check("last_write_cycle", last_w, NC + 2);
      check("done_cycle", done_cyc, NC + 3);
      check("sb_left", sb.size(), 0);
    end
    sb.delete();
  endtask

  initial begin
    tbl[0] = '{pa: 0, pb: 1, restart_at: 0,   reset_at: 0,   exp_dones: 1, exp_writes: NN, exp_c0: -1};
    tbl[1] = '{pa: 2, pb: 2, restart_at: 0,   reset_at: 0,   exp_dones: 1, exp_writes: NN, exp_c0: 1040400};
    tbl[2] = '{pa: 1, pb: 1, restart_at: 100, reset_at: 0,   exp_dones: 1, exp_writes: NN, exp_c0: -1};
    tbl[3] = '{pa: 1, pb: 1, restart_at: 0,   reset_at: 300, exp_dones: 0, exp_writes: 18, exp_c0: -1};
    tbl[4] = '{pa: 1, pb: 1, restart_at: 0,   reset_at: 0,   exp_dones: 1, exp_writes: NN, exp_c0: -1};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, rd_en, we_c}, 0);
    check("reset_addr_a", addr_a, 0);
    check("reset_addr_b", addr_b, 0);
    check("reset_addr_c", addr_c, 0);
    check("reset_c_data", c_data, 0);

    // rst and start together: reset wins, nothing starts
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    check("rst_prio_rd_en", rd_en, 0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prio_idle", {busy, rd_en}, 0);

    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t]);
      repeat (2) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_sequencer.md
MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 The block SHALL have parameter DIM_LOG2, default 6, meaning log2 of the square matrix dimension N (N=64).
REQ-002 The block SHALL have parameter DW, default 8, meaning the unsigned element width of A and B.
REQ-003 The block SHALL have parameter CW, default 22, meaning the accumulator and C element width.
REQ-004 Port clk, input, 1, is the single clock; all logic is rising-edge triggered.
REQ-005 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-006 Port start, input, 1, requests one full C = A x B run.
REQ-007 Port busy, output, 1, is high from the first issue cycle through the done cycle.
REQ-008 Port done, output, 1, is a one-cycle pulse at run completion.
REQ-009 Port rd_en, output, 1, enables reads of MEM_A and MEM_B.
REQ-010 Port addr_a, output, 2*DIM_LOG2, is the MEM_A read address.
REQ-011 Port addr_b, output, 2*DIM_LOG2, is the MEM_B read address.
REQ-012 Port a_data, input, DW, is MEM_A read data, valid one cycle after rd_en.
REQ-013 Port b_data, input, DW, is MEM_B read data, valid one cycle after rd_en.
REQ-014 Port we_c, output, 1, is the MEM_C write enable.
REQ-015 Port addr_c, output, 2*DIM_LOG2, is the MEM_C write address.
REQ-016 Port c_data, output, CW, is the MEM_C write data, driven from the accumulator register.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on start=1; RUN->DRAIN after issuing (i,j,k)=(N-1,N-1,N-1); DRAIN lasts 2 cycles; DONE lasts 1 cycle, then IDLE.
REQ-018 In RUN the block SHALL issue one read per cycle with rd_en=1, nested loops i (outer), j, k (inner), all starting at 0.
REQ-019 Addresses SHALL be addr_a={i,k}, addr_b={k,j}, addr_c={i,j} (row-major concatenation).
REQ-020 One cycle after issuing k=0, acc SHALL load a_data*b_data; for k>0, acc SHALL load acc+a_data*b_data (unsigned).
REQ-021 Products SHALL be 2*DW bits and zero-extended to CW; max sum 64*255*255=4161600 fits 22 bits, so no saturation or overflow logic is required.
REQ-022 Two cycles after issuing k=N-1 for (i,j), we_c SHALL be 1 for exactly one cycle with addr_c={i,j} and c_data equal to the final sum.
REQ-023 The pipeline SHALL not stall: a C write and the next element's k=0 accumulate occur in the same cycle.
REQ-024 start SHALL be sampled only in IDLE; start while busy=1 SHALL be ignored and SHALL NOT restart or queue a run.
REQ-025 With start sampled at edge 0, the first issue SHALL occur in cycle 1, the last issue in cycle 262144, the last we_c in cycle 262146, and done in cycle 262147.
REQ-026 rd_en SHALL be 0 outside RUN; we_c SHALL be 1 only for the 4096 writes of a run.
REQ-027 Exactly N*N=4096 writes SHALL occur per run, to each C address exactly once, in ascending address order.

Reset
REQ-028 On rst=1 at a rising edge the FSM SHALL enter IDLE and busy, done, rd_en, and we_c SHALL be 0; addr_a, addr_b, addr_c, c_data, acc, and the i/j/k counters SHALL be 0.
REQ-029 Reset mid-run SHALL abort immediately with no further reads or writes; a later start SHALL begin a fresh run from (0,0,0).
REQ-030 rst SHALL take priority over start in the same cycle.

Verification
REQ-031 A=identity, B=random -> MEM_C equals B in all 4096 entries, with zero mismatches.
REQ-032 A=B=all 0xFF -> every C entry = 22'h3F8040 (4161600).
REQ-033 Pulse start, then count cycles -> first rd_en in cycle 1 with addr_a=0, addr_b=0; cycle 2 addr_a=1, addr_b=64; done in cycle 262147 only; busy low afterward.
REQ-034 Pulse start again at cycle 1000 of a run -> no restart, a single done, and 4096 writes total.
REQ-035 Assert rst at cycle 5000 of a run -> all outputs 0 next cycle and no we_c until a new start; rerun -> full correct result.
REQ-036 Random A and B compared against a reference model -> all C entries match, and the first write is addr_c=0 in cycle 66.
